// File: rtl/si_sample_sink.sv
// SI bus write-slave: queues in-window 32-bit writes in a word FIFO and
// drains them as a little-endian valid/ready byte stream.
module si_sample_sink #(
   parameter logic [31:0] BASE_ADDR   = 32'hA000_0000,
   parameter int unsigned WIN_BYTES   = 256,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          exec,
   input  logic                          we,
   input  logic [31:0]                   si_address,
   input  logic [31:0]                   si_data,
   output logic                          fin,
   output logic                          addr_err,
   output logic [7:0]                    byte_data,
   output logic                          byte_valid,
   input  logic                          byte_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   drop_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StPush, StDone} state_e;

   state_e        r_state;
   state_e        w_state_next;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_data;
   logic [2:0]    r_wait_cnt;
   logic          r_addr_err;
   logic [15:0]   r_drop_cnt;
   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [31:0]   r_word;
   logic [1:0]    r_byte_idx;
   logic          r_busy;

   logic [31:0]   w_offset;
   logic          w_in_win;
   logic          w_ok;
   logic          w_full;
   logic          w_push;
   logic          w_drop;
   logic          w_wait_done;
   logic          w_accept;
   logic          w_last;
   logic          w_pop;
   logic [31:0]   w_shifted;

   // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
   assign w_offset    = r_addr - BASE_ADDR;
   assign w_in_win    = w_offset < WIN_BYTES;
   assign w_ok        = r_we & w_in_win;
   assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_push      = (r_state == StPush) & w_ok & ~w_full;
   assign w_drop      = (r_state == StPush) & ~w_ok;
   assign w_wait_done = (r_wait_cnt == 3'(WAIT_STATES - 1));

   assign w_accept  = r_busy & byte_ready;
   assign w_last    = w_accept & (r_byte_idx == 2'd3);
   assign w_pop     = (~r_busy | w_last) & (r_count != '0);
   assign w_shifted = r_word >> {r_byte_idx, 3'b000};

   always_ff @(posedge clk) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (exec) w_state_next = (WAIT_STATES > 0) ? StWait : StPush;
         StWait:  if (w_wait_done) w_state_next = StPush;
         StPush:  if (w_push || w_drop) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      fin = (r_state == StDone);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_wait_cnt <= '0;
         r_addr_err <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (r_state == StIdle && exec) begin
            r_we   <= we;
            r_addr <= si_address;
            r_data <= si_data;
         end
         r_wait_cnt <= (r_state == StWait) ? r_wait_cnt + 3'd1 : 3'd0;
         if (w_drop) begin
            r_addr_err <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_word     <= '0;
         r_byte_idx <= '0;
         r_busy     <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A pop on the last accepted byte refills the unpacker without a bubble.
         if (w_pop) begin
            r_word     <= r_mem[r_rd_ptr];
            r_byte_idx <= 2'd0;
            r_busy     <= 1'b1;
         end else if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last) r_busy <= 1'b0;
         end
      end
   end

   assign byte_data  = w_shifted[7:0];
   assign byte_valid = r_busy;
   assign fifo_level = r_count;
   assign addr_err   = r_addr_err;
   assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_si_sample_sink.sv
// Bench for si_sample_sink: directed and randomized SI writes checked against
// a queue-based byte-stream model and an error/drop counter model.
module tb_si_sample_sink;

   localparam logic [31:0] BASE  = 32'hA000_0000;
   localparam int unsigned WIN   = 256;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned WS    = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        exec;
   logic        we;
   logic [31:0] si_address;
   logic [31:0] si_data;
   logic        fin;
   logic        addr_err;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic [3:0]  fifo_level;
   logic [15:0] drop_cnt;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   bit          rand_ready = 1'b0;
   int          exp_drops = 0;
   bit          exp_err = 1'b0;

   si_sample_sink #(
      .BASE_ADDR  (BASE),
      .WIN_BYTES  (WIN),
      .FIFO_DEPTH (DEPTH),
      .WAIT_STATES(WS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .exec      (exec),
      .we        (we),
      .si_address(si_address),
      .si_data   (si_data),
      .fin       (fin),
      .addr_err  (addr_err),
      .byte_data (byte_data),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .fifo_level(fifo_level),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < WIN;
   endfunction

   // Handshake completes at the next posedge; inputs only move at posedge+1.
   always @(negedge clk) begin
      if (!reset && byte_valid && byte_ready) begin
         chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("byte_data", 32'(byte_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) byte_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic w);
      tick();
      exec = 1'b1;
      we = w;
      si_address = a;
      si_data = d;
      if (w && in_win(a)) begin
         for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
      end else begin
         exp_err = 1'b1;
         if (exp_drops < 65535) exp_drops++;
      end
      tick();
      exec = 1'b0;
   endtask

   task automatic wait_fin(input int limit, output int n, output bit got);
      n = 1;
      while (fin !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      got = (fin === 1'b1);
   endtask

   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic w);
      int n;
      bit got;
      start_write(a, d, w);
      wait_fin(40, n, got);
      chk({tag, "_fin"}, 32'(got), 32'd1);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      tick();
      tick();
      chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_valid_idle"}, 32'(byte_valid), 32'd0);
      chk({tag, "_level_idle"}, 32'(fifo_level), 32'd0);
   endtask

   initial begin
      int          n;
      bit          got;
      logic [31:0] a;
      logic [31:0] d;
      logic        w;

      reset = 1'b1;
      exec = 1'b0;
      we = 1'b0;
      si_address = '0;
      si_data = '0;
      byte_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_fin", 32'(fin), 0);
      chk("rst_valid", 32'(byte_valid), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_drop", 32'(drop_cnt), 0);

      // Reset with data queued, an error latched and a transfer in flight.
      do_write("pre_w1", BASE + 32'h20, 32'hDEAD_BEEF, 1'b1);
      do_write("pre_w2", BASE + 32'h24, 32'h0BAD_F00D, 1'b1);
      do_write("pre_err", BASE + 32'h100, 32'h1, 1'b1);
      start_write(BASE + 32'h28, 32'h1234_5678, 1'b1);
      reset = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (fin) got = 1'b1;
      end
      reset = 1'b0;
      exp_q.delete();
      exp_drops = 0;
      exp_err = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (fin) got = 1'b1;
      end
      chk("abort_no_fin", 32'(got), 0);
      chk("abort_err", 32'(addr_err), 0);
      chk("abort_drop", 32'(drop_cnt), 0);
      chk("abort_valid", 32'(byte_valid), 0);
      chk("abort_data", 32'(byte_data), 0);
      chk("abort_level", 32'(fifo_level), 0);

      // Single write: latency and four back-to-back bytes.
      byte_ready = 1'b1;
      start_write(BASE + 32'h10, 32'h4433_2211, 1'b1);
      wait_fin(40, n, got);
      chk("single_fin", 32'(got), 1);
      chk("single_latency", 32'(n), WS + 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("single_valid", 32'(byte_valid), 1);
      end
      tick();
      chk("single_done", 32'(byte_valid), 0);
      chk("single_left", 32'(exp_q.size()), 0);

      // Errors: just past the window, then a read.
      do_write("err_oow", BASE + 32'h100, 32'hAAAA_AAAA, 1'b1);
      do_write("err_read", BASE, 32'h5555_5555, 1'b0);
      chk("err_flag", 32'(addr_err), 1);
      chk("err_drop", 32'(drop_cnt), 2);
      chk("err_valid", 32'(byte_valid), 0);

      // Backpressure: one word parks in the unpacker, DEPTH more fill the FIFO.
      byte_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++)
         do_write("bp_w", BASE + 32'(4 * i), $urandom, 1'b1);
      chk("bp_level_full", 32'(fifo_level), DEPTH);
      chk("bp_hold_valid", 32'(byte_valid), 1);
      chk("bp_hold_data", 32'(byte_data), 32'(exp_q[0]));
      start_write(BASE + 32'h80, $urandom, 1'b1);
      wait_fin(20, n, got);
      chk("bp_fin_withheld", 32'(got), 0);
      byte_ready = 1'b1;
      wait_fin(40, n, got);
      chk("bp_fin_release", 32'(got), 1);
      drain("bp");

      // Burst with random downstream readiness.
      rand_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         a = BASE + 32'(4 * i);
         do_write("burst_w", a, a, 1'b1);
      end
      rand_ready = 1'b0;
      byte_ready = 1'b1;
      drain("burst");
      chk("burst_drop", 32'(drop_cnt), 32'(exp_drops));

      // Window edges.
      do_write("edge_top", BASE + 32'hFF, 32'hC0FF_EE01, 1'b1);
      chk("edge_top_drop", 32'(drop_cnt), 32'(exp_drops));
      do_write("edge_below", 32'h9FFF_FFFF, 32'h1, 1'b1);
      chk("edge_below_drop", 32'(drop_cnt), 32'(exp_drops));
      do_write("edge_high", 32'hFFFF_FFFC, 32'h2, 1'b1);
      chk("edge_high_drop", 32'(drop_cnt), 32'(exp_drops));
      drain("edge");

      // Random mix around the window.
      rand_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         a = BASE - 32'd64 + 32'($urandom_range(0, 383));
         d = $urandom;
         w = ($urandom_range(0, 4) != 0);
         do_write("mix_w", a, d, w);
      end
      rand_ready = 1'b0;
      byte_ready = 1'b1;
      drain("mix");
      chk("mix_drop", 32'(drop_cnt), 32'(exp_drops));
      chk("mix_err", 32'(addr_err), 32'(exp_err));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
